// File: rtl/vga_mono_filter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mono_filter
//  Description : Three-stage pixel pipeline that recolours a VGA stream into
//                one of several monochrome "monitor" looks (green, amber,
//                grey, cyan, inverted grey) or passes colour through.
//                Mode changes are deferred to the next vsync leading edge so
//                a frame is never rendered in two modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mono_filter #(
    parameter int IN_W     = 6,
    parameter int OUT_W    = 6,
    parameter int SYNC_POL = 0
) (
    input  logic             clk_vga,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [IN_W-1:0]  r_in,
    input  logic [IN_W-1:0]  g_in,
    input  logic [IN_W-1:0]  b_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             blank_in,
    output logic [OUT_W-1:0] r_out,
    output logic [OUT_W-1:0] g_out,
    output logic [OUT_W-1:0] b_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             blank_out,
    output logic [2:0]       mode_act
);

    // Product width: 183 < 2^8, so each weighted channel fits in IN_W+8 bits;
    // the three-term sum gets two extra bits of headroom.
    localparam int   c_PW         = IN_W + 8;
    localparam int   c_SW         = IN_W + 10;
    localparam logic c_SYNC_ACT   = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic c_SYNC_INACT = ~c_SYNC_ACT;

    // ------------------------------------------------------------------
    // Mode control
    // ------------------------------------------------------------------
    logic [2:0] pending_q, pending_d;
    logic [2:0] mode_act_q, mode_act_d;
    logic       vs_prev_q;
    logic       w_vs_lead;

    assign w_vs_lead = (vs_in == c_SYNC_ACT) && (vs_prev_q != c_SYNC_ACT);

    // The edge loads the next-pending value so that a mode written in the
    // very cycle of the vsync leading edge is still honoured at that edge.
    always_comb begin
        pending_d  = mode;
        mode_act_d = mode_act_q;
        if (w_vs_lead) begin
            mode_act_d = pending_d;
        end
    end

    // Pending mode, applied mode and vsync edge-detector registers
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            pending_q  <= 3'd0;
            mode_act_q <= 3'd0;
            vs_prev_q  <= c_SYNC_INACT;
        end else begin
            pending_q  <= pending_d;
            mode_act_q <= mode_act_d;
            vs_prev_q  <= vs_in;
        end
    end

    // pending_q is the architectural holding register; only its next value
    // feeds the edge load, so its registered copy has no further reader.
    logic w_unused_pending;
    assign w_unused_pending = ^pending_q;

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [IN_W-1:0] r1_q, g1_q, b1_q;
    logic [c_PW-1:0] pr1_q, pg1_q, pb1_q;
    logic [2:0]      m1_q;
    logic [IN_W-1:0] r2_q, g2_q, b2_q;
    logic [c_SW-1:0] sum2_q, w_sum_d;
    logic [IN_W-1:0] y2_q;
    logic [2:0]      m2_q;
    logic [2:0]      hs_pipe_q, vs_pipe_q, bl_pipe_q;
    logic [IN_W-1:0] w_r3, w_g3, w_b3;
    logic [OUT_W-1:0] r_out_q, g_out_q, b_out_q;

    assign w_sum_d = c_SW'(pr1_q) + c_SW'(pg1_q) + c_SW'(pb1_q);

    // S1 input/product registers and S2 sum/luma registers
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r1_q   <= '0;
            g1_q   <= '0;
            b1_q   <= '0;
            pr1_q  <= '0;
            pg1_q  <= '0;
            pb1_q  <= '0;
            m1_q   <= 3'd0;
            r2_q   <= '0;
            g2_q   <= '0;
            b2_q   <= '0;
            sum2_q <= '0;
            y2_q   <= '0;
            m2_q   <= 3'd0;
        end else begin
            r1_q   <= r_in;
            g1_q   <= g_in;
            b1_q   <= b_in;
            pr1_q  <= c_PW'(r_in) * c_PW'(54);
            pg1_q  <= c_PW'(g_in) * c_PW'(183);
            pb1_q  <= c_PW'(b_in) * c_PW'(19);
            m1_q   <= mode_act_q;
            r2_q   <= r1_q;
            g2_q   <= g1_q;
            b2_q   <= b1_q;
            sum2_q <= w_sum_d;
            // Weights total 256, so the luma cannot exceed the channel max.
            y2_q   <= IN_W'(w_sum_d >> 8);
            m2_q   <= m1_q;
        end
    end

    // Sum kept for observability of the intermediate; luma is taken directly.
    logic w_unused_sum;
    assign w_unused_sum = ^sum2_q;

    // Sync/blank delay lines matching the three data stages
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            hs_pipe_q <= {3{c_SYNC_INACT}};
            vs_pipe_q <= {3{c_SYNC_INACT}};
            bl_pipe_q <= 3'b111;
        end else begin
            hs_pipe_q <= {hs_pipe_q[1:0], hs_in};
            vs_pipe_q <= {vs_pipe_q[1:0], vs_in};
            bl_pipe_q <= {bl_pipe_q[1:0], blank_in};
        end
    end

    // S3 mode mux, driven by the mode that travelled with this pixel
    always_comb begin
        w_r3 = r2_q;
        w_g3 = g2_q;
        w_b3 = b2_q;
        case (m2_q)
            3'd1: begin w_r3 = '0;    w_g3 = y2_q;       w_b3 = '0;    end
            3'd2: begin w_r3 = y2_q;  w_g3 = y2_q >> 1;  w_b3 = '0;    end
            3'd3: begin w_r3 = y2_q;  w_g3 = y2_q;       w_b3 = y2_q;  end
            3'd4: begin w_r3 = '0;    w_g3 = y2_q;       w_b3 = y2_q;  end
            3'd5: begin w_r3 = ~y2_q; w_g3 = ~y2_q;      w_b3 = ~y2_q; end
            default: ;
        endcase
    end

    // S3 output registers: keep the top OUT_W bits, black during blanking
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_out_q <= '0;
            g_out_q <= '0;
            b_out_q <= '0;
        end else if (bl_pipe_q[1]) begin
            r_out_q <= '0;
            g_out_q <= '0;
            b_out_q <= '0;
        end else begin
            r_out_q <= OUT_W'(w_r3 >> (IN_W - OUT_W));
            g_out_q <= OUT_W'(w_g3 >> (IN_W - OUT_W));
            b_out_q <= OUT_W'(w_b3 >> (IN_W - OUT_W));
        end
    end

    assign r_out     = r_out_q;
    assign g_out     = g_out_q;
    assign b_out     = b_out_q;
    assign hs_out    = hs_pipe_q[2];
    assign vs_out    = vs_pipe_q[2];
    assign blank_out = bl_pipe_q[2];
    assign mode_act  = mode_act_q;

endmodule
`default_nettype wire

// File: doc/vga_mono_filter.md
VGA_MONO_FILTER -- requirements
Module: vga_mono_filter

Interface
REQ-001 SHALL have parameter IN_W, default 6: width of each input colour channel.
REQ-002 SHALL have parameter OUT_W, default 6: width of each output colour channel; OUT_W <= IN_W.
REQ-003 SHALL have parameter SYNC_POL, default 0: active level of hsync/vsync (0 = active-low).
REQ-004 SHALL have clk_vga  input  1: pixel clock; all logic on its rising edge; one clock, no other clock domains.
REQ-005 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have mode  input  3: requested filter mode (0 colour, 1 green, 2 amber, 3 grey, 4 cyan, 5 inverted grey, 6/7 colour).
REQ-007 SHALL have r_in, g_in, b_in  input  IN_W each: source pixel.
REQ-008 SHALL have hs_in, vs_in, blank_in  input  1 each: source syncs (SYNC_POL level) and blank (active-high).
REQ-009 SHALL have r_out, g_out, b_out  output  OUT_W each: filtered pixel.
REQ-010 SHALL have hs_out, vs_out, blank_out  output  1 each: delayed syncs/blank.
REQ-011 SHALL have mode_act  output  3: mode currently applied.

Function
REQ-012 SHALL compute luma Y = (54*R + 183*G + 19*B) >> 8 with full-width intermediates (IN_W+10 bits); Y SHALL never exceed 2^IN_W-1, no saturation logic.
REQ-013 SHALL be a 3-stage pipeline: S1 registers inputs and the three products; S2 registers the sum and Y; S3 registers the mode mux result; latency exactly 3 clk_vga cycles for every mode, colour bypass included.
REQ-014 SHALL delay hs, vs, blank through 3 registers so they stay aligned with pixel data.
REQ-015 S3 mapping (IN_W values): mode 0/6/7 R,G,B unchanged; 1 (0,Y,0); 2 (Y,Y>>1,0); 3 (Y,Y,Y); 4 (0,Y,Y); 5 (~Y,~Y,~Y).
REQ-016 SHALL form each output as the top OUT_W bits of the IN_W S3 value (truncation, no rounding).
REQ-017 SHALL force r_out/g_out/b_out to 0 in any cycle where blank_out is 1.
REQ-018 SHALL latch mode into a pending register every cycle; mode_act SHALL load pending only on the vsync leading edge (vs_in transitioning from inactive to SYNC_POL level), detected with a registered copy of vs_in.
REQ-019 Mode changes mid-frame SHALL NOT alter output until the next vsync leading edge; several changes within a frame: last value before the edge wins.
REQ-020 Mode change in the same cycle as the vsync leading edge SHALL take effect at that edge.
REQ-021 The S3 mux SHALL use mode_act as seen by the pixel in S3 (mode_act pipelined alongside data), so no pixel within a frame mixes modes.
REQ-022 No handshake; one pixel accepted and one produced every cycle, no stalls.

Reset
REQ-023 While rst=1: all pipeline data registers, r_out/g_out/b_out and mode_act/pending = 0; blank_out = 1; hs_out/vs_out = inactive (~SYNC_POL); vsync-edge detector register = inactive.
REQ-024 Reset asserted mid-frame SHALL discard in-flight pixels; first valid output appears 3 cycles after rst deasserts; mode_act stays 0 until the first vsync leading edge after reset.

Verification
REQ-025 IN_W=OUT_W=6, mode_act=3, input (63,63,63), blank=0 -> output (63,63,63) exactly 3 cycles later.
REQ-026 mode_act=1, input (63,0,0) -> output (0,13,0); mode_act=2, input (63,63,63) -> (63,31,0); mode_act=5, input (63,63,63) -> (0,0,0).
REQ-027 mode changed 0->3 mid-frame with input (63,0,0) -> output stays (63,0,0) until the first pixel after the next vsync leading edge, then (13,13,13); mode_act updates the cycle after the edge.
REQ-028 OUT_W=3, mode_act=3, input (63,63,63) -> (7,7,7); blank_in=1 with input (63,63,63) -> (0,0,0), blank_out=1, 3 cycles later.
REQ-029 Toggle hs_in/vs_in in a random pattern -> hs_out/vs_out reproduce it delayed exactly 3 cycles, SYNC_POL=0 and 1.
REQ-030 Assert rst for 1 cycle mid-line in mode 2 -> next cycle outputs 0, blank_out=1, syncs inactive, mode_act=0; colour passthrough resumes 3 cycles after rst falls.
